// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types, S-box and GF(2^8) helpers for the forward cipher.
package aes_pkg;

  localparam int NR      = 10;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = BLOCK_W * (NR + 1);

  typedef logic [7:0]         byte_t;
  typedef logic [BLOCK_W-1:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_e;

  // Index 0 is the leftmost byte, so the table reads row by row as printed in FIPS-197.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX[b];
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul2(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t gmul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/aes_fwd_cipher_if.sv
// Request/result bundle between the encryption client and the iterative AES-128 cipher.
interface aes_fwd_cipher_if;
  import aes_pkg::*;

  logic             start;
  block_t           in;
  logic [KEY_W-1:0] wordin;
  logic             busy;
  block_t           out;
  logic             out_valid;

  modport master (
    output start, in, wordin,
    input  busy, out, out_valid
  );

  modport slave (
    input  start, in, wordin,
    output busy, out, out_valid
  );

endinterface

// File: rtl/aes_fwd_round.sv
// One combinational AES forward round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_fwd_round
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t rkey_i,
  input  logic   final_i,
  output block_t state_o
);

  // Byte n sits at state[127-8n -: 8]; column c = n/4, row r = n%4.
  byte_t sb [16];
  byte_t sr [16];
  byte_t mc [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_shift
    assign sb[gi] = sbox(state_i[127-8*gi -: 8]);
    // Row r rotates left by r columns: out[r][c] = in[r][(c+r)%4].
    assign sr[gi] = sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    assign mc[4*gi+0] = gmul2(sr[4*gi+0]) ^ gmul3(sr[4*gi+1]) ^ sr[4*gi+2] ^ sr[4*gi+3];
    assign mc[4*gi+1] = sr[4*gi+0] ^ gmul2(sr[4*gi+1]) ^ gmul3(sr[4*gi+2]) ^ sr[4*gi+3];
    assign mc[4*gi+2] = sr[4*gi+0] ^ sr[4*gi+1] ^ gmul2(sr[4*gi+2]) ^ gmul3(sr[4*gi+3]);
    assign mc[4*gi+3] = gmul3(sr[4*gi+0]) ^ sr[4*gi+1] ^ sr[4*gi+2] ^ gmul2(sr[4*gi+3]);
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_ark
    assign state_o[127-8*gi -: 8] = (final_i ? sr[gi] : mc[gi]) ^ rkey_i[127-8*gi -: 8];
  end

endmodule

// File: rtl/aes_fwd_cipher.sv
// Iterative AES-128 encryptor, one round per clock, 11 edges from accepted start to out_valid.
// Define AES_KEY_LATCH_EN to capture the expanded key at start instead of reading wordin live.
module aes_fwd_cipher
  import aes_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  aes_fwd_cipher_if.slave bus
);

  state_e           fsm_q, fsm_d;
  block_t           state_q, state_d;
  block_t           out_q, out_d;
  logic [3:0]       rnd_q, rnd_d;
  logic             out_valid_q, out_valid_d;
  logic [KEY_W-1:0] key_src;
  block_t           rkey;
  block_t           round_out;
  logic             accept;

  assign accept = (fsm_q == IDLE) && bus.start;

`ifdef AES_KEY_LATCH_EN
  logic [KEY_W-1:0] key_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_q <= '0;
    end else if (accept) begin
      key_q <= bus.wordin;
    end
  end

  assign key_src = key_q;
`else
  assign key_src = bus.wordin;
`endif

  // Round-key select; counter values past NR fall through to zero and are never consumed.
  always_comb begin
    rkey = '0;
    for (int r = 0; r <= NR; r++) begin
      if (rnd_q == r[3:0]) begin
        rkey = key_src[128*r +: 128];
      end
    end
  end

  aes_fwd_round u_round (
    .state_i (state_q),
    .rkey_i  (rkey),
    .final_i (fsm_q == FINAL),
    .state_o (round_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_d       = rnd_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        rnd_d = '0;
        if (bus.start) begin
          // Round 0 is a bare AddRoundKey, always taken straight from wordin.
          state_d = bus.in ^ bus.wordin[127:0];
          rnd_d   = 4'd1;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        if (rnd_q >= 4'd1 && rnd_q < 4'(NR)) begin
          state_d = round_out;
          rnd_d   = rnd_q + 4'd1;
          if (rnd_q == 4'(NR - 1)) begin
            fsm_d = FINAL;
          end
        end else begin
          fsm_d = IDLE;
          rnd_d = '0;
        end
      end
      FINAL: begin
        if (rnd_q == 4'(NR)) begin
          out_d       = round_out;
          out_valid_d = 1'b1;
        end
        fsm_d = IDLE;
        rnd_d = '0;
      end
      default: begin
        fsm_d = IDLE;
        rnd_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rnd_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.busy      = (fsm_q != IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/aes_fwd_cipher.md
Name: aes_fwd_cipher

Overview:
Iterative AES-128 forward cipher (encryption), the counterpart of the existing inverse-cipher datapath. It computes one round per clock from a precomputed 11-round expanded key bus supplied by the key-expansion block. It has a start/busy/valid handshake and one registered 128-bit output. It sits in the encryption path, feeding ciphertext to the same downstream consumers as the decryption path.

Parameters:
NR, 10, number of AES rounds (fixed at 10 for AES-128; other values unsupported)
KEY_W, 1408, expanded-key bus width = 128*(NR+1)

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
in  in  128  plaintext; column words w0=in[127:96] .. w3=in[31:0], byte [31:24] of each word = row 0
wordin  in  1408  expanded key; round key r = wordin[128r+127:128r], r=0..10
busy  out  1  high while a block is in flight
out  out  128  ciphertext, same byte layout as in
out_valid  out  1  one-cycle pulse when out is updated

Behaviour:
- Reset (async assert, sync release): state regs=0, round counter=0, FSM=IDLE, busy=0, out=0, out_valid=0.
- FSM states: IDLE, RUN, FINAL.
- IDLE + start=1 at edge k:
  - state <= in ^ wordin[127:0]
  - rnd <= 1
  - busy <= 1
  - FSM <= RUN
- RUN, edges k+1..k+9:
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ roundkey[rnd]
  - rnd++
  - after the edge where rnd becomes 10, FSM <= FINAL
- FINAL, edge k+10:
  - out <= ShiftRows(SubBytes(state)) ^ roundkey[10] (no MixColumns)
  - out_valid <= 1 for exactly one cycle
  - busy <= 0
  - FSM <= IDLE
- Latency: start sampled at edge k gives out_valid high during the cycle after edge k+10. This is 11 edges; throughput is one block per 11 cycles.
- Back-to-back: start may be asserted in the cycle where out_valid=1. It is accepted at the next edge, so the next block's out_valid arrives 11 cycles after the first.
- start while busy=1: ignored, no queuing.
- in is sampled only at the accepting edge. Without the optional feature, wordin must stay stable from the accepting edge through edge k+10.
- out holds its value until the next FINAL or reset; out_valid=0 otherwise.
- Reset mid-operation: block is aborted, busy=0, no out_valid. out is cleared to 0.
- Arithmetic: GF(2^8) with polynomial 0x11B. MixColumns matrix rows are [02 03 01 01] rotated. S-box as FIPS-197.
- rnd is 4 bits; values 11..15 are unreachable. An illegal FSM/rnd value recovers to IDLE.

Optional Feature:
AES_KEY_LATCH_EN:
- Defined: a 1408-bit key register captures wordin at the accepting edge, and all rounds use the registered copy. wordin may change freely after start.
- Undefined: no key register; rounds read wordin live, and the stability rule above applies.

Decomposition:
- Package aes_pkg:
  - NR, block/key width constants
  - 8-bit byte and 128-bit block typedefs
  - S-box constant table or sbox function
  - xtime/gmul2/gmul3 functions
  - FSM state enum (IDLE/RUN/FINAL)
- Sub-module aes_fwd_round: combinational, inputs state[127:0], rkey[127:0], final flag; output next state. SubBytes → ShiftRows → (MixColumns unless final) → AddRoundKey.
- Top keeps the FSM, round counter, state/out registers and round-key mux.

Test Plan:
- FIPS-197 App. C.1: in=00112233445566778899aabbccddeeff, key 000102..0f expanded on wordin, start 1 cycle → out=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 1 cycle, exactly 11 edges after start edge; busy high for those cycles.
- FIPS-197 App. B: in=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → out=3925841d02dc09fbdc118597196a0b32; round-1 internal state = a49c7ff2689f352b6b5bea43026a5049 (intermediate check).
- Start held high continuously with two alternating blocks → outputs every 11 cycles, both correct; starts during busy produce no extra out_valid.
- RST_N pulsed low at round 5 of a block → busy=0, out=0, no out_valid; a fresh start then produces the correct App. C.1 result.
- With AES_KEY_LATCH_EN: wordin randomised the cycle after start → App. C.1 result unchanged. Without the macro: same stimulus → mismatch, and the checker flags the stability violation.
- Round-trip: feed out into the inverse cipher with the matching key schedule → original plaintext recovered for 100 random key/plaintext pairs.
